// File: rtl/edit_field_ctrl.sv
// Editing-cursor controller for the clock/date/chrono display.
// Turns four synchronized button levels into a mode/field state machine.
// Drives blinking highlight flags and inc/dec/commit strobes, with
// auto-repeat on held up/down.
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | not editing, all flags off, up/down/next ignored
// S_HORA  | editing time fields H/M/S
// S_FECHA | editing date fields D/M/A
// S_CRONO | editing chrono fields H/M/S
module edit_field_ctrl #(
  parameter int BLINK_DIV   = 12_500_000,
  parameter int REPEAT_DLY  = 12_500_000,
  parameter int REPEAT_RATE = 2_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       edit_active,
  output logic [1:0] group_sel,
  output logic [1:0] field_sel,
  output logic       bandera_Hhora,
  output logic       bandera_Mhora,
  output logic       bandera_Shora,
  output logic       bandera_Dfecha,
  output logic       bandera_Mfecha,
  output logic       bandera_Afecha,
  output logic       bandera_Hcrono,
  output logic       bandera_Mcrono,
  output logic       bandera_Scrono,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       commit_pulse
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [RPT_W-1:0]   DLY_LAST   = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0]   RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HORA  = 2'd1,
    S_FECHA = 2'd2,
    S_CRONO = 2'd3
  } state_t;

  // button bit order: 0 mode, 1 next, 2 up, 3 down
  state_t               r_state;
  logic [1:0]           r_field;
  logic [3:0]           r_btn_s;
  logic [3:0]           r_btn_q;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_blink_on;
  logic [RPT_W-1:0]     r_rpt_cnt;
  logic                 r_rpt_act;
  logic                 r_rpt_rate;
  logic                 r_rpt_dn;
  logic                 r_next_pend;
  logic [8:0]           r_flags;
  logic                 r_inc;
  logic                 r_dec;
  logic                 r_commit;
  logic                 r_edit;

  logic [3:0]           w_rise;
  logic                 w_edit;
  logic                 w_both;
  logic                 w_inc;
  logic                 w_dec;
  logic                 w_strobe;
  logic                 w_commit;
  logic [RPT_W-1:0]     w_rpt_cnt_nxt;
  logic                 w_rpt_act_nxt;
  logic                 w_rpt_rate_nxt;
  logic                 w_rpt_dn_nxt;
  state_t               w_state_nxt;
  logic [1:0]           w_field_nxt;
  logic                 w_pend_nxt;
  logic                 w_reload;
  logic [BLINK_W-1:0]   w_blink_cnt_nxt;
  logic                 w_blink_on_nxt;
  logic [3:0]           w_base;
  logic [3:0]           w_idx;
  logic [8:0]           w_flags_nxt;

  // Event decode, repeat timing, next state/field, blink and flag selection
  always_comb begin
    w_rise         = r_btn_s & ~r_btn_q;
    w_edit         = (r_state != S_IDLE);
    w_both         = r_btn_s[2] & r_btn_s[3];
    w_inc          = 1'b0;
    w_dec          = 1'b0;
    w_rpt_cnt_nxt  = r_rpt_cnt;
    w_rpt_act_nxt  = r_rpt_act;
    w_rpt_rate_nxt = r_rpt_rate;
    w_rpt_dn_nxt   = r_rpt_dn;

    // A mode rise discards up/down, and a both-pressed chord holds the counter at 0.
    if (!w_edit || w_rise[0] || w_both) begin
      w_rpt_act_nxt  = 1'b0;
      w_rpt_cnt_nxt  = '0;
      w_rpt_rate_nxt = 1'b0;
    end else if (w_rise[2] || w_rise[3]) begin
      w_inc          = w_rise[2];
      w_dec          = w_rise[3];
      w_rpt_act_nxt  = 1'b1;
      w_rpt_cnt_nxt  = '0;
      w_rpt_rate_nxt = 1'b0;
      w_rpt_dn_nxt   = w_rise[3];
    end else if (r_rpt_act && (r_rpt_dn ? r_btn_s[3] : r_btn_s[2])) begin
      if (r_rpt_cnt == (r_rpt_rate ? RATE_LAST : DLY_LAST)) begin
        w_inc          = ~r_rpt_dn;
        w_dec          = r_rpt_dn;
        w_rpt_cnt_nxt  = '0;
        w_rpt_rate_nxt = 1'b1;
      end else begin
        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
      end
    end else begin
      w_rpt_act_nxt  = 1'b0;
      w_rpt_cnt_nxt  = '0;
      w_rpt_rate_nxt = 1'b0;
    end
    w_strobe = w_inc | w_dec;

    w_state_nxt = r_state;
    w_field_nxt = r_field;
    w_pend_nxt  = r_next_pend;
    w_commit    = 1'b0;
    if (w_rise[0]) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_HORA;
        S_HORA:  w_state_nxt = S_FECHA;
        S_FECHA: w_state_nxt = S_CRONO;
        default: w_state_nxt = S_IDLE;
      endcase
      w_field_nxt = 2'd0;
      w_pend_nxt  = 1'b0;
      w_commit    = w_edit;
    end else if (w_edit && (w_rise[1] || r_next_pend)) begin
      // A strobe in the same cycle must still address the old field,
      // so the advance waits one cycle.
      if (w_strobe) begin
        w_pend_nxt = 1'b1;
      end else begin
        w_field_nxt = (r_field == 2'd2) ? 2'd0 : r_field + 2'd1;
        w_pend_nxt  = 1'b0;
      end
    end

    w_reload = (w_state_nxt != r_state) || (w_field_nxt != r_field) || w_strobe;
    if (w_reload) begin
      w_blink_cnt_nxt = '0;
      w_blink_on_nxt  = 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_blink_cnt_nxt = '0;
      w_blink_on_nxt  = ~r_blink_on;
    end else begin
      w_blink_cnt_nxt = r_blink_cnt + 1'b1;
      w_blink_on_nxt  = r_blink_on;
    end

    case (w_state_nxt)
      S_HORA:  w_base = 4'd0;
      S_FECHA: w_base = 4'd3;
      default: w_base = 4'd6;
    endcase
    w_idx       = w_base + {2'b00, w_field_nxt};
    w_flags_nxt = '0;
    if (w_state_nxt != S_IDLE && w_field_nxt != 2'd3)
      w_flags_nxt[w_idx] = w_blink_on_nxt;
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_field     <= 2'd0;
      r_btn_s     <= '0;
      r_btn_q     <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_rpt_cnt   <= '0;
      r_rpt_act   <= 1'b0;
      r_rpt_rate  <= 1'b0;
      r_rpt_dn    <= 1'b0;
      r_next_pend <= 1'b0;
      r_flags     <= '0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_commit    <= 1'b0;
      r_edit      <= 1'b0;
    end else begin
      r_btn_s     <= {btn_down, btn_up, btn_next, btn_mode};
      r_btn_q     <= r_btn_s;
      r_state     <= w_state_nxt;
      r_field     <= w_field_nxt;
      r_next_pend <= w_pend_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_on  <= w_blink_on_nxt;
      r_rpt_cnt   <= w_rpt_cnt_nxt;
      r_rpt_act   <= w_rpt_act_nxt;
      r_rpt_rate  <= w_rpt_rate_nxt;
      r_rpt_dn    <= w_rpt_dn_nxt;
      r_flags     <= w_flags_nxt;
      r_inc       <= w_inc;
      r_dec       <= w_dec;
      r_commit    <= w_commit;
      r_edit      <= (w_state_nxt != S_IDLE);
    end
  end

  assign edit_active    = r_edit;
  assign group_sel      = r_state;
  assign field_sel      = r_field;
  assign inc_pulse      = r_inc;
  assign dec_pulse      = r_dec;
  assign commit_pulse   = r_commit;
  assign bandera_Hhora  = r_flags[0];
  assign bandera_Mhora  = r_flags[1];
  assign bandera_Shora  = r_flags[2];
  assign bandera_Dfecha = r_flags[3];
  assign bandera_Mfecha = r_flags[4];
  assign bandera_Afecha = r_flags[5];
  assign bandera_Hcrono = r_flags[6];
  assign bandera_Mcrono = r_flags[7];
  assign bandera_Scrono = r_flags[8];

endmodule
